mul_div_unit: RTL and testbench

//   Iterative multi-cycle multiply/divide unit for LEGv8 MUL, SMULH, UMULH, UDIV and SDIV.

---
 rtl/mdu_pkg.sv | 24 ++
 rtl/mul_div_unit.sv | 172 +++++++++++++++++
 tb/tb_mul_div_unit.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Op codes, FSM states and the per-operation latency.
package mdu_pkg;

  localparam int WORD = 64;
  localparam int LAT  = WORD + 3;

  typedef enum logic [2:0] {
    OP_MUL   = 3'b000,
    OP_SMULH = 3'b001,
    OP_UMULH = 3'b010,
    OP_UDIV  = 3'b100,
    OP_SDIV  = 3'b101
  } mdu_op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_FIX,
    S_DONE
  } mdu_state_t;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle.
// Multiply and divide share one 2*WIDTH shift register and one adder.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter  int WIDTH = WORD,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero
);

  mdu_state_t state, state_n;

  logic [CNT_W-1:0]   cnt;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   opa;
  logic [WIDTH-1:0]   opb;
  logic               neg;
  logic [2*WIDTH-1:0] acc;

  logic               is_div;
  logic               is_sgn;
  logic               last;
  logic               sa;
  logic               sb;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

  assign is_div = op_q[2];
  assign is_sgn = (op_q == OP_SMULH)
                | (op_q == OP_SDIV);
  assign last   = cnt == CNT_W'(WIDTH-1);

  // MIN keeps its bit pattern, read back as unsigned 2^(WIDTH-1)
  assign sa    = is_sgn & opa[WIDTH-1];
  assign sb    = is_sgn & opb[WIDTH-1];
  assign mag_a = sa ? -opa : opa;
  assign mag_b = sb ? -opb : opb;

  logic [WIDTH+1:0]   as_x;
  logic [WIDTH+1:0]   as_y;
  logic [WIDTH+1:0]   as_r;
  logic               ge;
  logic [2*WIDTH-1:0] acc_step;

  always_comb begin
    as_x = '0;
    as_y = '0;
    as_r = '0;
    if (is_div) begin
      as_x = {1'b0, acc[2*WIDTH-1:WIDTH-1]};
      as_y = {2'b0, opb};
      as_r = as_x - as_y;
    end else begin
      as_x = {2'b0, acc[2*WIDTH-1:WIDTH]};
      as_y = acc[0] ? {2'b0, opa} : '0;
      as_r = as_x + as_y;
    end
  end

  assign ge = ~as_r[WIDTH+1];

  always_comb begin
    acc_step = acc;
    if (is_div) begin
      acc_step = {
        ge ? as_r[WIDTH-1:0]
           : acc[2*WIDTH-2:WIDTH-1],
        acc[WIDTH-2:0],
        ge
      };
    end else begin
      acc_step = {
        as_r[WIDTH:0],
        acc[WIDTH-1:1]
      };
    end
  end

  logic [2*WIDTH-1:0] acc_sgn;
  logic [WIDTH-1:0]   res_c;
  logic               dz_c;

  assign acc_sgn = neg ? -acc : acc;

  always_comb begin
    res_c = '0;
    dz_c  = 1'b0;
    unique case (op_q)
      OP_MUL:   res_c = acc[WIDTH-1:0];
      OP_SMULH: res_c = acc_sgn[2*WIDTH-1:WIDTH];
      OP_UMULH: res_c = acc[2*WIDTH-1:WIDTH];
      OP_UDIV,
      OP_SDIV: begin
        if (opb == '0) dz_c  = 1'b1;
        else           res_c = acc_sgn[WIDTH-1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (start) state_n = S_PREP;
      S_PREP: state_n = S_ITER;
      S_ITER: if (last) state_n = S_FIX;
      S_FIX:  state_n = S_DONE;
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      op_q        <= '0;
      opa         <= '0;
      opb         <= '0;
      neg         <= 1'b0;
      acc         <= '0;
      result      <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            op_q <= op;
            opa  <= operand_a;
            opb  <= operand_b;
          end
        end
        S_PREP: begin
          opa <= mag_a;
          opb <= mag_b;
          neg <= sa ^ sb;
          cnt <= '0;
          acc <= is_div
               ? {{WIDTH{1'b0}}, mag_a}
               : {{WIDTH{1'b0}}, mag_b};
        end
        S_ITER: begin
          acc <= acc_step;
          cnt <= cnt + 1'b1;
        end
        S_FIX: begin
          result      <= res_c;
          div_by_zero <= dz_c;
        end
        default: ;
      endcase
    end
  end

  assign busy = state != S_IDLE;
  assign done = state == S_DONE;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: a cycle model predicts acceptance,
// busy/done timing and results; done pops and compares.
module tb_mul_div_unit;
  import mdu_pkg::*;

  localparam int W = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    op = 3'b000;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic          dz;

  int n_tests = 0;
  int n_fail  = 0;
  int mcnt    = 0;
  logic [W:0] q[$];
  logic [W:0] exp_v;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .operand_a   (a),
    .operand_b   (b),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .div_by_zero (dz)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] want
  );
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h @%0t",
               tag, got, want, $time);
    end
  endtask

  function automatic logic [W:0] model(
    input logic [2:0]   o,
    input logic [W-1:0] x,
    input logic [W-1:0] y
  );
    logic [2*W-1:0]        up;
    logic signed [2*W-1:0] sp;
    logic signed [W-1:0]   sq;
    up = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    sp = $signed({{W{x[W-1]}}, x})
       * $signed({{W{y[W-1]}}, y});
    case (o)
      3'b000: return {1'b0, up[W-1:0]};
      3'b001: return {1'b0, sp[2*W-1:W]};
      3'b010: return {1'b0, up[2*W-1:W]};
      3'b100: begin
        if (y == '0) return {1'b1, {W{1'b0}}};
        return {1'b0, x / y};
      end
      3'b101: begin
        if (y == '0) return {1'b1, {W{1'b0}}};
        if (x == {1'b1, {(W-1){1'b0}}} && y == '1)
          return {1'b0, x};
        sq = $signed(x) / $signed(y);
        return {1'b0, sq};
      end
      default: return '0;
    endcase
  endfunction

  // Reference timing: accept in idle, busy for W+3 edges, done on the last
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mcnt = 0;
      q.delete();
    end else if (mcnt == 0) begin
      if (start) begin
        q.push_back(model(op, a, b));
        mcnt = W + 3;
      end
    end else begin
      mcnt--;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("busy", 64'(busy), 64'(mcnt != 0));
      check("done", 64'(done), 64'(mcnt == 1));
      if (mcnt == 1) begin
        if (q.size() == 0) begin
          check("sb_empty", 64'(1), 64'(0));
        end else begin
          exp_v = q.pop_front();
          check("result", result, exp_v[W-1:0]);
          check("dbz", 64'(dz), 64'(exp_v[W]));
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (mcnt != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("timeout", 64'(1), 64'(0));
  endtask

  task automatic go(
    input logic [2:0]   o,
    input logic [W-1:0] x,
    input logic [W-1:0] y
  );
    @(negedge clk);
    wait_idle();
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = ~x;
    b     = y + 1;
    wait_idle();
  endtask

  logic [2:0] ops [5] = '{
    3'b000, 3'b001, 3'b010, 3'b100, 3'b101
  };

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got hang want finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_result", result, 64'(0));
    check("rst_dbz", 64'(dz), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    go(3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
    go(3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
    go(3'b001, -64'sd3, 64'd5);
    go(3'b000, -64'sd3, 64'd5);
    go(3'b101, -64'sd7, 64'd2);
    go(3'b100, 64'd100, 64'd7);
    go(3'b101, 64'h8000_0000_0000_0000, '1);
    go(3'b101, 64'd7, -64'sd2);
    go(3'b001, 64'h8000_0000_0000_0000,
               64'h8000_0000_0000_0000);
    go(3'b100, 64'd123456789, 64'd0);
    go(3'b100, 64'd10, 64'd3);
    go(3'b101, -64'sd9, 64'd0);
    go(3'b011, 64'd55, 64'd5);
    for (int i = 0; i < 6; i++) begin
      go(ops[$urandom_range(0, 4)],
         {$urandom, $urandom},
         {32'd0, $urandom});
    end

    // start held high with operands changing every cycle
    @(negedge clk);
    wait_idle();
    start = 1'b1;
    for (int i = 0; i < 200; i++) begin
      op = ops[$urandom_range(0, 4)];
      a  = {$urandom, $urandom};
      b  = {$urandom_range(0, 3) == 0 ? 32'd0 : $urandom,
            $urandom};
      @(negedge clk);
    end
    start = 1'b0;
    wait_idle();

    // asynchronous reset in the middle of an iteration
    @(negedge clk);
    op    = 3'b101;
    a     = -64'sd1000;
    b     = 64'd7;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (31) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_done", 64'(done), 64'(0));
    check("arst_result", result, 64'(0));
    check("arst_dbz", 64'(dz), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (80) @(negedge clk);
    go(3'b100, 64'd10, 64'd3);
    go(3'b000, 64'd12345, 64'd6789);

    repeat (3) @(negedge clk);
    check("sb_drain", 64'(q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
